// File: rtl/expr_eval.sv
// Running evaluator for a single-digit ASCII expression stream of digits, '+' and '*',
// with '*' binding tighter than '+'. Outputs reflect the longest complete prefix so far.
module expr_eval #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [7:0]   in,
    output logic [W-1:0] result,
    output logic         valid,
    output logic         err
);

    typedef enum logic [1:0] {
        EXP_DIG = 2'd0,
        EXP_OP  = 2'd1,
        ERR     = 2'd2
    } state_t;

    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_STAR = 8'h2A;

    state_t       state_q, state_d;
    logic [W-1:0] sum_q, sum_d;
    logic [W-1:0] prod_q, prod_d;
    logic         mul_q, mul_d;
    logic [W-1:0] result_q, result_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;

    logic         is_digit;
    logic [W-1:0] digit_w;

    // The low nibble of an ASCII digit is its numeric value.
    assign is_digit = (in >= 8'h30) && (in <= 8'h39);
    assign digit_w  = {{(W-4){1'b0}}, in[3:0]};

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        prod_d   = prod_q;
        mul_d    = mul_q;
        result_d = result_q;
        valid_d  = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            EXP_DIG: begin
                if (is_digit) begin
                    if (mul_q) begin
                        prod_d = prod_q * digit_w;
                    end else begin
                        // A new additive term starts: fold the finished product into the sum.
                        sum_d  = sum_q + prod_q;
                        prod_d = digit_w;
                    end
                    state_d = EXP_OP;
                end else begin
                    state_d = ERR;
                end
            end
            EXP_OP: begin
                if (in == CH_PLUS) begin
                    mul_d   = 1'b0;
                    state_d = EXP_DIG;
                end else if (in == CH_STAR) begin
                    mul_d   = 1'b1;
                    state_d = EXP_DIG;
                end else begin
                    state_d = ERR;
                end
            end
            default: state_d = ERR;
        endcase

        if (state_d == EXP_OP) begin
            valid_d  = 1'b1;
            result_d = sum_d + prod_d;
        end else if (state_d == ERR) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= EXP_DIG;
            sum_q    <= '0;
            prod_q   <= '0;
            mul_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            prod_q   <= prod_d;
            mul_q    <= mul_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign result = result_q;
    assign valid  = valid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_expr_eval.sv
// Directed-vector bench for expr_eval: each task drives one scenario and checks outputs
// one time unit after the consuming clock edge.
module tb_expr_eval;

    logic        clk;
    logic        clr;
    logic [7:0]  in;
    logic [15:0] result;
    logic        valid;
    logic        err;

    int checks;
    int errors;

    expr_eval #(.W(16)) dut (
        .clk    (clk),
        .clr    (clr),
        .in     (in),
        .result (result),
        .valid  (valid),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        clr = 1'b0;
        in  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr(input logic [7:0] c);
        @(negedge clk);
        clr = 1'b1;
        in  = c;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic test_reset;
        do_clr("7");
        checks++;
        if (result !== 16'd0 || valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: result=%0d valid=%b err=%b required result=0 valid=0 err=0",
                     result, valid, err);
        end
        $display("reset with '7' on bus: result=%0d valid=%b err=%b", result, valid, err);
    endtask

    task automatic test_basic;
        string s = "1+2*3";
        logic exp_v [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int   exp_r [5] = '{1, 1, 3, 3, 7};
        do_clr(8'h00);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            checks++;
            if (valid !== exp_v[i] || result !== 16'(exp_r[i]) || err !== 1'b0) begin
                errors++;
                $display("FAIL basic[%0d]: result=%0d valid=%b err=%b required result=%0d valid=%b err=0",
                         i, result, valid, err, exp_r[i], exp_v[i]);
            end
            $display("basic char '%s': result=%0d valid=%b err=%b", s.substr(i, i), result, valid, err);
        end
        send("3");
        checks++;
        if (err !== 1'b1 || valid !== 1'b0 || result !== 16'd7) begin
            errors++;
            $display("FAIL basic_multidigit: result=%0d valid=%b err=%b required result=7 valid=0 err=1",
                     result, valid, err);
        end
        $display("basic repeated '3': result=%0d valid=%b err=%b", result, valid, err);
    endtask

    task automatic test_precedence;
        string s = "2*3+4*5";
        int exp_r [7] = '{2, 2, 6, 6, 10, 10, 26};
        do_clr(8'h00);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            checks++;
            if (result !== 16'(exp_r[i]) || valid !== ((i % 2) == 0) || err !== 1'b0) begin
                errors++;
                $display("FAIL precedence[%0d]: result=%0d valid=%b err=%b required result=%0d valid=%b err=0",
                         i, result, valid, err, exp_r[i], (i % 2) == 0);
            end
            $display("precedence char '%s': result=%0d valid=%b", s.substr(i, i), result, valid);
        end
    endtask

    task automatic test_overflow;
        string s = "9*9*9*9*9*9";
        do_clr(8'h00);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            if (i == 8) begin
                checks++;
                if (result !== 16'd59049 || valid !== 1'b1) begin
                    errors++;
                    $display("FAIL overflow_9pow5: result=%0d valid=%b required result=59049 valid=1",
                             result, valid);
                end
            end
            $display("overflow char '%s': result=%0d valid=%b err=%b", s.substr(i, i), result, valid, err);
        end
        checks++;
        if (result !== 16'd7153 || valid !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL overflow_wrap: result=%0d valid=%b err=%b required result=7153 valid=1 err=0",
                     result, valid, err);
        end
    endtask

    task automatic test_leading_plus;
        string s = "+12";
        do_clr(8'h00);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            checks++;
            if (err !== 1'b1 || valid !== 1'b0 || result !== 16'd0) begin
                errors++;
                $display("FAIL leading_plus[%0d]: result=%0d valid=%b err=%b required result=0 valid=0 err=1",
                         i, result, valid, err);
            end
            $display("leading_plus char '%s': result=%0d valid=%b err=%b", s.substr(i, i), result, valid, err);
        end
    endtask

    task automatic test_clr_mid;
        do_clr(8'h00);
        send("1");
        send("+");
        do_clr("9");
        checks++;
        if (result !== 16'd0 || valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL clr_mid: result=%0d valid=%b err=%b required result=0 valid=0 err=0",
                     result, valid, err);
        end
        $display("clr_mid after clr: result=%0d valid=%b err=%b", result, valid, err);
        send("5");
        checks++;
        if (result !== 16'd5 || valid !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL clr_mid_restart: result=%0d valid=%b err=%b required result=5 valid=1 err=0",
                     result, valid, err);
        end
        $display("clr_mid char '5': result=%0d valid=%b err=%b", result, valid, err);
    endtask

    task automatic test_bad_char;
        do_clr(8'h00);
        send("4");
        send(8'h61);
        checks++;
        if (err !== 1'b1 || valid !== 1'b0 || result !== 16'd4) begin
            errors++;
            $display("FAIL bad_char: result=%0d valid=%b err=%b required result=4 valid=0 err=1",
                     result, valid, err);
        end
        $display("bad_char 'a': result=%0d valid=%b err=%b", result, valid, err);
        do_clr(8'h00);
        checks++;
        if (err !== 1'b0 || valid !== 1'b0 || result !== 16'd0) begin
            errors++;
            $display("FAIL bad_char_clr: result=%0d valid=%b err=%b required result=0 valid=0 err=0",
                     result, valid, err);
        end
        send("3");
        checks++;
        if (result !== 16'd3 || valid !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL bad_char_restart: result=%0d valid=%b err=%b required result=3 valid=1 err=0",
                     result, valid, err);
        end
        $display("bad_char restart '3': result=%0d valid=%b err=%b", result, valid, err);
    endtask

    task automatic test_back_to_back;
        string s = "3*3*3+1+2*2";
        do_clr(8'h00);
        for (int i = 0; i < s.len(); i++) send(s[i]);
        checks++;
        if (result !== 16'd32 || valid !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: result=%0d valid=%b err=%b required result=32 valid=1 err=0",
                     result, valid, err);
        end
        $display("back_to_back 3*3*3+1+2*2: result=%0d valid=%b err=%b", result, valid, err);
        send("*");
        checks++;
        if (result !== 16'd32 || valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_op: result=%0d valid=%b err=%b required result=32 valid=0 err=0",
                     result, valid, err);
        end
        send("0");
        checks++;
        if (result !== 16'd28 || valid !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_zero: result=%0d valid=%b err=%b required result=28 valid=1 err=0",
                     result, valid, err);
        end
        $display("back_to_back *0: result=%0d valid=%b err=%b", result, valid, err);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr    = 1'b1;
        in     = 8'h00;
        test_reset();
        test_basic();
        test_precedence();
        test_overflow();
        test_leading_plus();
        test_clr_mid();
        test_bad_char();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
